// File: rtl/fetch_unit.sv
// Instruction fetch stage: holds the PC, addresses insnmem, and queues fetched
// words with their PC in a small buffer drained by decode over valid/ready.
module fetch_unit #(
  parameter int AW       = 8,
  parameter int DEPTH    = 2,
  parameter int RESET_PC = 0
) (
  input  logic          clk,
  input  logic          reset,
  output logic [AW-1:0] imem_a,
  input  logic [31:0]   imem_rd,
  input  logic          redirect_valid,
  input  logic [AW-1:0] redirect_pc,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_insn,
  output logic [AW-1:0] out_pc,
  output logic [AW-1:0] out_pc_plus4,
  output logic          fsm_state
);

  // Handshake: the head entry is transferred to decode on every rising edge
  // where out_valid and out_ready are both high; out_* hold while
  // out_valid & ~out_ready, and out_valid never drops without a pop,
  // a redirect or a reset.

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [AW-1:0] ALIGN_MASK = ~AW'(3);
  localparam logic [AW-1:0] PC_STEP    = AW'(4);
  localparam logic [AW-1:0] BOOT_PC    = AW'(RESET_PC) & ALIGN_MASK;
  localparam logic [CW-1:0] FULL_CNT   = CW'(DEPTH);

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e          state, state_next;
  logic [AW-1:0]   pc;
  logic [PW-1:0]   rd_ptr, wr_ptr;
  logic [CW-1:0]   count, count_next;
  logic [31:0]     insn_q [DEPTH];
  logic [AW-1:0]   pc_q   [DEPTH];
  logic            run, pop, push;

  assign fsm_state = state;

  always_comb begin
    state_next = state;
    run        = 1'b0;
    case (state)
      BOOT: state_next = RUN;
      RUN:  run        = 1'b1;
      default: state_next = BOOT;
    endcase
  end

  assign out_valid    = (count != '0);
  assign pop          = out_valid & out_ready;
  // A full buffer still accepts a new word when the head leaves this cycle.
  assign push         = run & ~redirect_valid & ((count < FULL_CNT) | pop);
  assign imem_a       = pc;
  assign out_insn     = insn_q[rd_ptr];
  assign out_pc       = pc_q[rd_ptr];
  assign out_pc_plus4 = pc_q[rd_ptr] + PC_STEP;

  always_comb begin
    count_next = count;
    if (push && !pop)
      count_next = count + CW'(1);
    else if (pop && !push)
      count_next = count - CW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= BOOT;
      pc     <= BOOT_PC;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        insn_q[i] <= '0;
        pc_q[i]   <= '0;
      end
    end else begin
      state <= state_next;
      if (redirect_valid) begin
        // Redirect flushes everything, including a head accepted this cycle.
        pc     <= redirect_pc & ALIGN_MASK;
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) begin
          insn_q[wr_ptr] <= imem_rd;
          pc_q[wr_ptr]   <= pc;
          wr_ptr         <= wr_ptr + PW'(1);
          pc             <= pc + PC_STEP;
        end
        if (pop)
          rd_ptr <= rd_ptr + PW'(1);
        count <= count_next;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit with a byte-array insnmem model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  imem_a;
  logic [31:0] imem_rd;
  logic        redirect_valid = 1'b0;
  logic [7:0]  redirect_pc = 8'h00;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_insn;
  logic [7:0]  out_pc;
  logic [7:0]  out_pc_plus4;
  logic        fsm_state;

  logic [7:0]  mem [256];
  logic [7:0]  exp_q [$];
  int          n_checks = 0;
  int          n_fail = 0;

  fetch_unit #(.AW(8), .DEPTH(2), .RESET_PC(0)) dut (
    .clk(clk), .reset(reset), .imem_a(imem_a), .imem_rd(imem_rd),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_insn(out_insn),
    .out_pc(out_pc), .out_pc_plus4(out_pc_plus4), .fsm_state(fsm_state)
  );

  // Clock / reset block
  initial forever #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Little-endian combinational insnmem model
  logic [7:0] a1, a2, a3;
  assign a1 = imem_a + 8'd1;
  assign a2 = imem_a + 8'd2;
  assign a3 = imem_a + 8'd3;
  always_comb imem_rd = {mem[a3], mem[a2], mem[a1], mem[imem_a]};

  function automatic logic [31:0] word_at(input logic [7:0] a);
    logic [7:0] b1, b2, b3;
    b1 = a + 8'd1;
    b2 = a + 8'd2;
    b3 = a + 8'd3;
    return {mem[b3], mem[b2], mem[b1], mem[a]};
  endfunction

  // Driver tasks: inputs change and outputs are sampled 1ns after posedge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    redirect_valid = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    out_ready = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    n_checks++; if (imem_a !== 8'h00) begin n_fail++; $display("FAIL reset_imem_a: got %h want 00", imem_a); end
    n_checks++; if (out_insn !== 32'h0) begin n_fail++; $display("FAIL reset_insn: got %h want 0", out_insn); end
    n_checks++; if (out_pc !== 8'h00) begin n_fail++; $display("FAIL reset_pc: got %h want 00", out_pc); end
    n_checks++; if (out_pc_plus4 !== 8'h04) begin n_fail++; $display("FAIL reset_pc_plus4: got %h want 04", out_pc_plus4); end
    n_checks++; if (fsm_state !== 1'b0) begin n_fail++; $display("FAIL reset_state: got %b want 0", fsm_state); end
    reset = 1'b0;
    tick();
    n_checks++; if (imem_a !== 8'h00) begin n_fail++; $display("FAIL boot_imem_a: got %h want 00", imem_a); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL boot_valid: got %b want 0", out_valid); end
    n_checks++; if (fsm_state !== 1'b1) begin n_fail++; $display("FAIL boot_state: got %b want 1", fsm_state); end
  endtask

  task automatic test_stream();
    out_ready = 1'b1;
    tick();
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL stream_valid0: got %b want 1", out_valid); end
    n_checks++; if (out_insn !== 32'h00000000) begin n_fail++; $display("FAIL stream_insn0: got %h want 00000000", out_insn); end
    n_checks++; if (out_pc !== 8'h00) begin n_fail++; $display("FAIL stream_pc0: got %h want 00", out_pc); end
    tick();
    n_checks++; if (out_insn !== 32'h04030201) begin n_fail++; $display("FAIL stream_insn1: got %h want 04030201", out_insn); end
    n_checks++; if (out_pc !== 8'h04) begin n_fail++; $display("FAIL stream_pc1: got %h want 04", out_pc); end
    n_checks++; if (out_pc_plus4 !== 8'h08) begin n_fail++; $display("FAIL stream_pc_plus4: got %h want 08", out_pc_plus4); end
  endtask

  task automatic test_stall();
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    n_checks++; if (imem_a !== 8'h08) begin n_fail++; $display("FAIL stall_imem_a: got %h want 08", imem_a); end
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL stall_valid: got %b want 1", out_valid); end
    n_checks++; if (out_pc !== 8'h00) begin n_fail++; $display("FAIL stall_head_pc: got %h want 00", out_pc); end
    out_ready = 1'b1;
    tick();
    n_checks++; if (out_pc !== 8'h04) begin n_fail++; $display("FAIL stall_rel_pc1: got %h want 04", out_pc); end
    n_checks++; if (out_insn !== 32'h04030201) begin n_fail++; $display("FAIL stall_rel_insn1: got %h want 04030201", out_insn); end
    tick();
    n_checks++; if (out_pc !== 8'h08) begin n_fail++; $display("FAIL stall_rel_pc2: got %h want 08", out_pc); end
    n_checks++; if (out_insn !== 32'h08070605) begin n_fail++; $display("FAIL stall_rel_insn2: got %h want 08070605", out_insn); end
  endtask

  task automatic test_redirect();
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    redirect_valid = 1'b1;
    redirect_pc = 8'h42;
    tick();
    redirect_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL redir_valid: got %b want 0", out_valid); end
    n_checks++; if (imem_a !== 8'h40) begin n_fail++; $display("FAIL redir_imem_a: got %h want 40", imem_a); end
    tick();
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL redir_valid2: got %b want 1", out_valid); end
    n_checks++; if (out_pc !== 8'h40) begin n_fail++; $display("FAIL redir_pc: got %h want 40", out_pc); end
    n_checks++; if (out_insn !== 32'h403F3E3D) begin n_fail++; $display("FAIL redir_insn: got %h want 403F3E3D", out_insn); end
    n_checks++; if (out_pc_plus4 !== 8'h44) begin n_fail++; $display("FAIL redir_pc_plus4: got %h want 44", out_pc_plus4); end
  endtask

  task automatic test_wrap();
    out_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 8'hFC;
    tick();
    redirect_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL wrap_flush_valid: got %b want 0", out_valid); end
    n_checks++; if (imem_a !== 8'hFC) begin n_fail++; $display("FAIL wrap_imem_a: got %h want FC", imem_a); end
    tick();
    n_checks++; if (out_pc !== 8'hFC) begin n_fail++; $display("FAIL wrap_pc: got %h want FC", out_pc); end
    n_checks++; if (out_insn !== 32'hFCFBFAF9) begin n_fail++; $display("FAIL wrap_insn: got %h want FCFBFAF9", out_insn); end
    n_checks++; if (out_pc_plus4 !== 8'h00) begin n_fail++; $display("FAIL wrap_pc_plus4: got %h want 00", out_pc_plus4); end
    n_checks++; if (imem_a !== 8'h00) begin n_fail++; $display("FAIL wrap_imem_a2: got %h want 00", imem_a); end
    tick();
    n_checks++; if (out_pc !== 8'h00) begin n_fail++; $display("FAIL wrap_next_pc: got %h want 00", out_pc); end
    n_checks++; if (out_insn !== 32'h00000000) begin n_fail++; $display("FAIL wrap_next_insn: got %h want 00000000", out_insn); end
  endtask

  task automatic test_mid_reset();
    out_ready = 1'b0;
    tick();
    tick();
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL midrst_pre_valid: got %b want 1", out_valid); end
    #2;
    reset = 1'b1;
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_async_valid: got %b want 0", out_valid); end
    n_checks++; if (imem_a !== 8'h00) begin n_fail++; $display("FAIL midrst_async_imem_a: got %h want 00", imem_a); end
    tick();
    reset = 1'b0;
    out_ready = 1'b1;
    tick();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_boot_valid: got %b want 0", out_valid); end
    tick();
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL midrst_restart_valid: got %b want 1", out_valid); end
    n_checks++; if (out_pc !== 8'h00) begin n_fail++; $display("FAIL midrst_restart_pc: got %h want 00", out_pc); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] a;
    do_reset();
    out_ready = 1'b1;
    tick();
    for (int k = 0; k < 8; k++) begin
      a = 8'(4 * k);
      n_checks++; if (out_pc !== a || out_insn !== word_at(a)) begin n_fail++; $display("FAIL b2b_%0d: got pc %h insn %h want pc %h insn %h", k, out_pc, out_insn, a, word_at(a)); end
      tick();
    end
  endtask

  // Scoreboard: expected PC order under an irregular out_ready pattern
  task automatic test_ready_pattern();
    logic [15:0] pattern;
    logic [7:0]  exp_pc;
    int          accepted;
    pattern = 16'b1011_0010_1100_1101;
    exp_q.delete();
    for (int k = 0; k < 16; k++) exp_q.push_back(8'(4 * k));
    accepted = 0;
    do_reset();
    for (int c = 0; c < 16; c++) begin
      out_ready = pattern[c];
      if (out_valid) begin
        exp_pc = exp_q[0];
        n_checks++; if (out_pc !== exp_pc || out_insn !== word_at(exp_pc)) begin n_fail++; $display("FAIL pattern_cyc%0d: got pc %h insn %h want pc %h insn %h", c, out_pc, out_insn, exp_pc, word_at(exp_pc)); end
        if (out_ready) begin
          void'(exp_q.pop_front());
          accepted++;
        end
      end
      tick();
    end
    n_checks++; if (accepted !== 8) begin n_fail++; $display("FAIL pattern_accepted: got %0d want 8", accepted); end
    out_ready = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = (i < 4) ? 8'h00 : 8'(i - 3);
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_wrap();
    test_mid_reset();
    test_back_to_back();
    test_ready_pattern();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
